// File: rtl/intdiv_otf_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : intdiv_otf_conv_pkg
// Brief   : Shared SD2 digit codes and converter state encoding for the
//           integer divider's on-the-fly quotient conversion.
// Revision: 1.0 - initial release
// ============================================================================
package intdiv_otf_conv_pkg;

  // SD2 digit is (p,n) with value p-n; both zero codes are equivalent
  localparam logic [1:0] c_POS1   = 2'b10;
  localparam logic [1:0] c_NEG1   = 2'b01;
  localparam logic [1:0] c_ZERO_1 = 2'b00;
  localparam logic [1:0] c_ZERO_2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : intdiv_otf_conv_pkg
`default_nettype wire

// File: rtl/intdiv_otf_step.sv
`default_nettype none
// ============================================================================
// Module  : intdiv_otf_step
// Brief   : One on-the-fly conversion step. Appends one SD2 digit to the
//           (Q, QM=Q-1) register pair without any carry-propagate add.
//           Purely combinational so it can be chained in unrolled dividers.
// Revision: 1.0 - initial release
// ============================================================================
module intdiv_otf_step
  import intdiv_otf_conv_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   dig,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  // The MSBs shift out; the result range guarantees they carry no information
  logic w_unused_msb;
  assign w_unused_msb = q[W-1] ^ qm[W-1];

  // Select which register each shifted copy comes from, based on the digit
  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (dig)
      c_POS1: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      c_NEG1: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      c_ZERO_1, c_ZERO_2: begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
      end
    endcase
  end

endmodule : intdiv_otf_step
`default_nettype wire

// File: rtl/intdiv_otf_conv.sv
`default_nettype none
// ============================================================================
// Module  : intdiv_otf_conv
// Brief   : Serial on-the-fly converter from MSB-first SD2 quotient digits
//           to an (N+1)-bit two's-complement quotient, with optional -1
//           correction for a negative final remainder.
// Revision: 1.0 - initial release
// ============================================================================
module intdiv_otf_conv
  import intdiv_otf_conv_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dig_valid,
  input  logic [1:0]   dig,
  input  logic         rem_neg,
  output logic         dig_ready,
  output logic         busy,
  output logic         quo_valid,
  output logic [N:0]   quo,
  input  logic         quo_ack
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [N:0]       r_q;
  logic [N:0]       r_qm;
  logic [N:0]       w_q_next;
  logic [N:0]       w_qm_next;
  logic [CNT_W-1:0] r_cnt;
  logic [N:0]       r_quo;
  logic             r_quo_valid;
  logic             w_quo_valid_next;
  logic             w_load;
  logic             w_accept;
  logic             w_last;

  intdiv_otf_step #(
    .W (N + 1)
  ) u_step (
    .q       (r_q),
    .qm      (r_qm),
    .dig     (dig),
    .q_next  (w_q_next),
    .qm_next (w_qm_next)
  );

  assign w_accept = dig_valid && (r_state == ST_CONV);
  assign w_last   = (r_cnt == c_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, register-load strobe and quo_valid update; start beats ack in DONE
  always_comb begin
    w_state_next     = r_state;
    w_load           = 1'b0;
    w_quo_valid_next = r_quo_valid;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        if (w_accept && w_last) begin
          w_quo_valid_next = 1'b1;
          w_state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_load           = 1'b1;
          w_quo_valid_next = 1'b0;
          w_state_next     = ST_CONV;
        end else if (quo_ack) begin
          w_quo_valid_next = 1'b0;
          w_state_next     = ST_IDLE;
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_quo_valid_next = 1'b0;
      end
    endcase
  end

  // Q/QM pair and digit counter: reinitialise on start, advance on each accepted digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_qm  <= '1;
      r_cnt <= '0;
    end else if (w_load) begin
      r_q   <= '0;
      r_qm  <= '1;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_q   <= w_q_next;
      r_qm  <= w_qm_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result capture with the last digit; QM_next already equals Q_next-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo       <= '0;
      r_quo_valid <= 1'b0;
    end else begin
      r_quo_valid <= w_quo_valid_next;
      if (w_accept && w_last) begin
        r_quo <= rem_neg ? w_qm_next : w_q_next;
      end
    end
  end

  assign dig_ready = (r_state == ST_CONV);
  assign busy      = (r_state == ST_CONV);
  assign quo_valid = r_quo_valid;
  assign quo       = r_quo;

endmodule : intdiv_otf_conv
`default_nettype wire

// File: tb/tb_intdiv_otf_conv.sv
`default_nettype none
// ============================================================================
// Module  : tb_intdiv_otf_conv
// Brief   : Self-checking bench for intdiv_otf_conv (N=4) with directed and
//           randomized digit streams against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_intdiv_otf_conv;

  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int W     = N + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         dig_valid;
  logic [1:0]   dig;
  logic         rem_neg;
  logic         dig_ready;
  logic         busy;
  logic         quo_valid;
  logic [W-1:0] quo;
  logic         quo_ack;

  int n_tests = 0;
  int n_fail  = 0;

  intdiv_otf_conv #(
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dig_valid (dig_valid),
    .dig       (dig),
    .rem_neg   (rem_neg),
    .dig_ready (dig_ready),
    .busy      (busy),
    .quo_valid (quo_valid),
    .quo       (quo),
    .quo_ack   (quo_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quotient = sum of digit values weighted MSB-first, minus one if remainder negative
  function automatic logic [W-1:0] ref_quo(input logic [2*N-1:0] digs, input logic rem);
    int v;
    logic [1:0] d;
    v = 0;
    for (int i = 0; i < N; i++) begin
      d = digs[2*(N-1-i) +: 2];
      v = v * 2;
      if (d == 2'b10) v = v + 1;
      else if (d == 2'b01) v = v - 1;
    end
    if (rem) v = v - 1;
    return v[W-1:0];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Start a conversion and feed N digits with 'gap' stall cycles before each one.
  // Reports the captured quotient, the number of cycles where the CONV-phase
  // outputs were wrong, and whether the DONE outputs appeared one clock after the last digit.
  task automatic do_conv(input logic [2*N-1:0] digs, input logic rem, input int gap,
                         output logic [W-1:0] got, output int bad, output bit valid_ok);
    bad       = 0;
    start     = 1'b1;
    dig_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        dig_valid = 1'b0;
        dig       = 2'($urandom);
        rem_neg   = 1'($urandom);
        if (dig_ready !== 1'b1 || busy !== 1'b1 || quo_valid !== 1'b0) bad++;
        tick();
      end
      dig_valid = 1'b1;
      dig       = digs[2*(N-1-i) +: 2];
      rem_neg   = (i == N - 1) ? rem : 1'($urandom);
      if (dig_ready !== 1'b1 || busy !== 1'b1 || quo_valid !== 1'b0) bad++;
      tick();
    end
    dig_valid = 1'b0;
    dig       = 2'($urandom);
    rem_neg   = 1'($urandom);
    valid_ok  = (quo_valid === 1'b1) && (busy === 1'b0) && (dig_ready === 1'b0);
    got       = quo;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dig_ready, busy, quo_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000", {dig_ready, busy, quo_valid});
    end
    n_tests++;
    if (quo !== '0) begin
      n_fail++;
      $display("FAIL reset_quo: got %b required %b", quo, {W{1'b0}});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [2*N-1:0] digs [5];
    logic           rems [5];
    logic [W-1:0]   exps [5];
    logic [W-1:0]   got;
    int             bad;
    bit             vok;
    digs[0] = 8'b10_00_01_10; rems[0] = 1'b0; exps[0] = 5'b00111;
    digs[1] = 8'b01_01_01_01; rems[1] = 1'b0; exps[1] = 5'b10001;
    digs[2] = 8'b10_10_10_10; rems[2] = 1'b0; exps[2] = 5'b01111;
    digs[3] = 8'b10_00_00_00; rems[3] = 1'b1; exps[3] = 5'b00111;
    digs[4] = 8'b10_11_11_11; rems[4] = 1'b1; exps[4] = 5'b00111;
    for (int k = 0; k < 5; k++) begin
      do_conv(digs[k], rems[k], 0, got, bad, vok);
      n_tests++;
      if (got !== exps[k]) begin
        n_fail++;
        $display("FAIL directed_quo[%0d]: got %b required %b", k, got, exps[k]);
      end
      n_tests++;
      if (!vok || bad != 0) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: valid_ok=%0d bad_cycles=%0d required 1/0", k, vok, bad);
      end
      quo_ack = 1'b1;
      tick();
      quo_ack = 1'b0;
      n_tests++;
      if (quo_valid !== 1'b0 || busy !== 1'b0 || quo !== exps[k]) begin
        n_fail++;
        $display("FAIL directed_ack[%0d]: quo_valid=%b busy=%b quo=%b required 0/0/%b",
                 k, quo_valid, busy, quo, exps[k]);
      end
    end
  endtask

  task automatic test_stalls();
    logic [W-1:0] got;
    int           bad;
    bit           vok;
    do_conv(8'b10_00_01_10, 1'b0, 3, got, bad, vok);
    n_tests++;
    if (got !== 5'b00111) begin
      n_fail++;
      $display("FAIL stall_quo: got %b required 00111", got);
    end
    n_tests++;
    if (!vok || bad != 0) begin
      n_fail++;
      $display("FAIL stall_timing: valid_ok=%0d bad_cycles=%0d required 1/0", vok, bad);
    end
    quo_ack = 1'b1;
    tick();
    quo_ack = 1'b0;
  endtask

  task automatic test_handshake();
    logic [W-1:0] got;
    int           bad;
    bit           vok;
    int           unstable;
    logic [1:0]   seq [4];
    do_conv(8'b10_00_01_10, 1'b0, 0, got, bad, vok);
    unstable = 0;
    quo_ack  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (quo_valid !== 1'b1 || quo !== 5'b00111 || busy !== 1'b0) unstable++;
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL hold_stable: got %0d unstable cycles required 0", unstable);
    end
    // start together with ack: start wins
    start   = 1'b1;
    quo_ack = 1'b1;
    tick();
    start   = 1'b0;
    quo_ack = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || quo_valid !== 1'b0 || dig_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ack: busy=%b quo_valid=%b dig_ready=%b required 1/0/1",
               busy, quo_valid, dig_ready);
    end
    // digits +1,+1,-1,-1 with start pulses in between must give 8+4-2-1 = 9
    seq[0] = 2'b10; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b01;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 2) begin
        start     = 1'b1;
        dig_valid = 1'b0;
        tick();
        if (busy !== 1'b1 || quo_valid !== 1'b0) bad++;
      end
      start     = (i == 1);
      dig_valid = 1'b1;
      dig       = seq[i];
      rem_neg   = 1'b0;
      tick();
    end
    start     = 1'b0;
    dig_valid = 1'b0;
    n_tests++;
    if (quo !== 5'b01001 || quo_valid !== 1'b1 || bad != 0) begin
      n_fail++;
      $display("FAIL start_in_conv: quo=%b quo_valid=%b bad=%0d required 01001/1/0",
               quo, quo_valid, bad);
    end
    quo_ack = 1'b1;
    tick();
    quo_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [2*N-1:0] digs;
    logic           rem;
    logic [W-1:0]   got;
    logic [W-1:0]   exp;
    int             bad;
    bit             vok;
    int             gap;
    for (int k = 0; k < 30; k++) begin
      digs = 8'($urandom);
      rem  = 1'($urandom);
      gap  = int'($urandom_range(0, 2));
      exp  = ref_quo(digs, rem);
      do_conv(digs, rem, gap, got, bad, vok);
      n_tests++;
      if (got !== exp || !vok || bad != 0) begin
        n_fail++;
        $display("FAIL random[%0d]: digs=%b rem=%b got %b required %b (valid_ok=%0d bad=%0d)",
                 k, digs, rem, got, exp, vok, bad);
      end
      // sometimes ack back to IDLE, otherwise restart straight from DONE
      if ($urandom_range(0, 1) == 1) begin
        quo_ack = 1'b1;
        tick();
        quo_ack = 1'b0;
      end
    end
    quo_ack = 1'b1;
    tick();
    quo_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got;
    int           bad;
    bit           vok;
    // leave a non-zero result in quo first
    do_conv(8'b10_10_10_10, 1'b0, 0, got, bad, vok);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dig_valid = 1'b1;
      dig       = 2'b10;
      tick();
    end
    dig_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dig_ready, busy, quo_valid} !== 3'b000 || quo !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: ctrl=%b quo=%b required 000/00000",
               {dig_ready, busy, quo_valid}, quo);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_conv(8'b00_00_00_01, 1'b0, 0, got, bad, vok);
    n_tests++;
    if (got !== 5'b11111 || !vok || bad != 0) begin
      n_fail++;
      $display("FAIL after_reset: got %b required 11111 (valid_ok=%0d bad=%0d)", got, vok, bad);
    end
    quo_ack = 1'b1;
    tick();
    quo_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    dig_valid = 1'b0;
    dig       = 2'b00;
    rem_neg   = 1'b0;
    quo_ack   = 1'b0;
    test_reset();
    test_directed();
    test_stalls();
    test_handshake();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_intdiv_otf_conv
`default_nettype wire
